fp16_div_seq: RTL and testbench
===============================

// Module: fp16_div_seq
// PURPOSE
//  Iterative IEEE-754 half-precision divider, q = x / y: the inverse operation to the fp16 multiplier in the fma16 datapath.
//  Restoring radix-2 mantissa divide, one quotient bit per cycle, then a single rounding cycle.
//  Sits beside the fma16 unit and shares its roundmode and flag conventions.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  NQ         13        quotient bits generated (11 significand + guard + round); must be >= 12
//  CANON_NAN  16'h7E00  value returned for every NaN result
// PORTS
//  clk        in   1   clock; all state updates on its rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   divider idle and able to accept operands
//  x          in   16  dividend, fp16
//  y          in   16  divisor, fp16
//  roundmode  in   2   00 RZ, 01 RNE, 10 RM (toward -inf), 11 RP (toward +inf)
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts the result
//  q          out  16  quotient, fp16
//  flags      out  5   {NV, DZ, OF, UF, NX}
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; q=16'h0000; flags=5'b0. Reset mid-operation abandons the operation; no result is emitted.
//  Accept: on a cycle with in_valid&&in_ready, x, y and roundmode are registered; in_ready drops the next cycle.
//  States and transitions:
//   IDLE  -> SPEC on accept when an operand is special; otherwise IDLE -> DIV on accept.
//   DIV   NQ cycles, one quotient bit per cycle, then -> RND.
//   RND   1 cycle; rounds, then -> DONE.
//   SPEC  1 cycle; loads the special result, then -> DONE.
//   DONE  out_valid=1; -> IDLE on out_ready. q and flags hold stable while out_ready=0.
//  Latency:
//   Normal operands: out_valid rises NQ+2 cycles after the accept edge (15 at default).
//   Special operands: out_valid rises 2 cycles after the accept edge.
//  in_ready is high only in IDLE, so there is no accept in the cycle a result is consumed. Throughput is one operation per NQ+3 cycles.
//  Subnormal inputs (exp==0, frac!=0) are treated as signed zero. Subnormal outputs are flushed to zero.
//  Sign: sx ^ sy for every non-NaN result, including zero and inf results.
//  Specials, in priority order:
//   1. Any NaN operand: q=CANON_NAN. NV=1 if either operand is an sNaN (frac[9]==0).
//   2. 0/0 or inf/inf: q=CANON_NAN, NV=1.
//   3. finite nonzero / 0: q=+/-inf, DZ=1.
//   4. inf/finite: q=+/-inf, no flags.
//   5. finite/inf or 0/finite nonzero: q=+/-0, no flags.
//  Datapath:
//   mx={1,fx}, my={1,fy}.
//   If mx<my: dividend=mx<<1 and e=ex-ey+14. Otherwise e=ex-ey+15. The quotient is then in [1,2).
//   e is a 7-bit signed value.
//   Iteration: rem=rem-my if rem>=my, setting qbit=1; then rem<<=1.
//   sticky = (final rem != 0).
//  Rounding on {q[NQ-1:2], guard, round|sticky}:
//   RNE ties to even; RZ truncates.
//   RM increments when sign=1 and the discarded bits are nonzero; RP increments when sign=0 and they are nonzero.
//   A significand carry-out renormalizes and increments e.
//   NX = any discarded bit nonzero.
//  Overflow (e>=31 after rounding): OF=1, NX=1.
//   q=inf for RNE; for RP when positive; for RM when negative.
//   q=16'h7BFF with the sign applied otherwise.
//  Underflow (e<=0): q=+/-0, UF=1, NX=1.
// STRUCTURE
//  fp16_pkg:
//   typedef enum {IDLE, DIV, RND, SPEC, DONE} fp16_div_state_t.
//   roundmode localparams RZ/RNE/RM/RP.
//   flag bit indices NV/DZ/OF/UF/NX.
//   CANON_NAN_H, INF_H, MAXFIN_H.
//  Sub-module fp16_div_special (combinational): classifies x and y as zero/inf/NaN/sNaN and produces is_special, special_q and special_flags.
//  Top level: FSM, iteration counter ($clog2(NQ+1) bits), remainder/quotient registers, rounding logic.
// TESTING
//  1. 0x4000/0x3C00, RNE -> q=0x4000, flags=0; out_valid exactly 15 cycles after the accept edge.
//  2. 0x3C00/0x4200 -> RNE q=0x3555, NX; RZ q=0x3555, NX; RP q=0x3556, NX.
//  3. 0x3C00/0x0000 -> q=0x7C00, DZ. 0x0000/0x0000 -> q=0x7E00, NV. 0x7D00/0x3C00 (sNaN) -> q=0x7E00, NV. All with out_valid 2 cycles after accept.
//  4. 0x7BFF/0x1400 -> RNE q=0x7C00, OF|NX; RZ q=0x7BFF, OF|NX. 0x0400/0x7800 -> q=0x0000, UF|NX.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> q and flags stable, in_ready=0; one cycle after out_ready=1, in_ready=1.
//  6. Deassert reset_n in the 7th DIV cycle -> immediate IDLE, out_valid=0. The next operation (0xC400/0x4000) returns 0xC000.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared fp16 divider definitions: FSM states, rounding modes, flag positions, constants.
// No logic; latency and backpressure are properties of the modules importing it.
// Flags are packed {NV, DZ, OF, UF, NX}.
package fp16_pkg;

    typedef enum logic [2:0] {IDLE, DIV, RND, SPEC, DONE} fp16_div_state_t;

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RM  = 2'b10;
    localparam logic [1:0] RP  = 2'b11;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    localparam logic [15:0] CANON_NAN_H = 16'h7E00;
    localparam logic [15:0] INF_H       = 16'h7C00;
    localparam logic [15:0] MAXFIN_H    = 16'h7BFF;

endpackage

// File: rtl/fp16_div_special.sv
// Classifies fp16 divide operands and builds the result for zero/inf/NaN cases.
// Latency: combinational.
// Backpressure: none; the caller samples the outputs when the operands are accepted.
module fp16_div_special import fp16_pkg::*; #(
    parameter logic [15:0] CANON_NAN = CANON_NAN_H
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        is_special,
    output logic [15:0] special_q,
    output logic [4:0]  special_flags
);

    logic xz, yz, xe, ye, xi, yi, xn, yn, xs, ys, sgn;

    // Subnormals share exponent 0 with zero and are treated as zero.
    assign xz  = (x[14:10] == 5'd0);
    assign yz  = (y[14:10] == 5'd0);
    assign xe  = (x[14:10] == 5'h1F);
    assign ye  = (y[14:10] == 5'h1F);
    assign xi  = xe && (x[9:0] == 10'd0);
    assign yi  = ye && (y[9:0] == 10'd0);
    assign xn  = xe && (x[9:0] != 10'd0);
    assign yn  = ye && (y[9:0] != 10'd0);
    assign xs  = xn && !x[9];
    assign ys  = yn && !y[9];
    assign sgn = x[15] ^ y[15];

    assign is_special = xz || yz || xe || ye;

    always_comb begin
        special_q     = {sgn, 15'd0};
        special_flags = '0;
        if (xn || yn) begin
            special_q         = CANON_NAN;
            special_flags[NV] = xs || ys;
        end else if ((xz && yz) || (xi && yi)) begin
            special_q         = CANON_NAN;
            special_flags[NV] = 1'b1;
        end else if (xi) begin
            special_q = {sgn, INF_H[14:0]};
        end else if (yz) begin
            special_q         = {sgn, INF_H[14:0]};
            special_flags[DZ] = 1'b1;
        end
    end

endmodule

// File: rtl/fp16_div_seq.sv
// Iterative fp16 divider q = x / y, restoring radix-2, one quotient bit per cycle.
// Latency: out_valid sampled high NQ+2 edges after accept (2 for special operands).
// Backpressure: result holds in DONE until out_ready; in_ready only in IDLE.
module fp16_div_seq import fp16_pkg::*; #(
    parameter int          NQ        = 13,
    parameter logic [15:0] CANON_NAN = CANON_NAN_H
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic [4:0]  flags
);

    localparam int CW = $clog2(NQ + 1);
    localparam logic [NQ-1:0] LOW_MASK = {NQ{1'b1}} >> 12;

    fp16_div_state_t   state;
    logic              sign;
    logic [1:0]        rmode;
    logic signed [6:0] e;
    logic [10:0]       my;
    logic [11:0]       rem;
    logic [NQ-1:0]     quo;
    logic [CW-1:0]     cnt;
    logic [15:0]       spec_q;
    logic [4:0]        spec_fl;

    logic              is_special;
    logic [15:0]       special_q;
    logic [4:0]        special_flags;

    fp16_div_special #(.CANON_NAN(CANON_NAN)) u_special (
        .x             (x),
        .y             (y),
        .is_special    (is_special),
        .special_q     (special_q),
        .special_flags (special_flags)
    );

    // Pre-shift the dividend when mx < my so the quotient lands in [1,2).
    logic [10:0]       mx_in, my_in;
    logic              lt;
    logic signed [6:0] e_in;
    assign mx_in = {1'b1, x[9:0]};
    assign my_in = {1'b1, y[9:0]};
    assign lt    = mx_in < my_in;
    assign e_in  = $signed({2'b00, x[14:10]}) - $signed({2'b00, y[14:10]})
                   + (lt ? 7'sd14 : 7'sd15);

    logic        ge;
    logic [11:0] rem_sub;
    assign ge      = rem >= {1'b0, my};
    assign rem_sub = ge ? (rem - {1'b0, my}) : rem;

    logic [10:0]       sig;
    logic              g, st, inexact, inc, carry, to_inf;
    logic [11:0]       sig_r;
    logic signed [6:0] e_r;
    logic [15:0]       rnd_q;
    logic [4:0]        rnd_fl;

    always_comb begin
        sig     = quo[NQ-1 -: 11];
        g       = quo[NQ-12];
        st      = (|(quo & LOW_MASK)) || (|rem);
        inexact = g || st;
        case (rmode)
            RNE:     inc = g && (st || sig[0]);
            RM:      inc = sign && inexact;
            RP:      inc = !sign && inexact;
            default: inc = 1'b0;
        endcase
        sig_r  = {1'b0, sig} + {11'd0, inc};
        // The hidden bit is always set, so a carry shows up as 2'b10 on top.
        carry  = (sig_r[11:10] == 2'b10);
        e_r    = e + $signed({6'd0, carry});
        to_inf = (rmode == RNE) || (rmode == RP && !sign) || (rmode == RM && sign);
        rnd_fl = '0;
        if (e_r >= 7'sd31) begin
            rnd_q      = to_inf ? {sign, INF_H[14:0]} : {sign, MAXFIN_H[14:0]};
            rnd_fl[OF] = 1'b1;
            rnd_fl[NX] = 1'b1;
        end else if (e_r <= 7'sd0) begin
            rnd_q      = {sign, 15'd0};
            rnd_fl[UF] = 1'b1;
            rnd_fl[NX] = 1'b1;
        end else begin
            rnd_q      = {sign, e_r[4:0], sig_r[9:0]};
            rnd_fl[NX] = inexact;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= 16'h0000;
            flags     <= 5'b0;
            sign      <= 1'b0;
            rmode     <= RZ;
            e         <= '0;
            my        <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            spec_q    <= '0;
            spec_fl   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign     <= x[15] ^ y[15];
                        rmode    <= roundmode;
                        spec_q   <= special_q;
                        spec_fl  <= special_flags;
                        my       <= my_in;
                        rem      <= lt ? {mx_in, 1'b0} : {1'b0, mx_in};
                        e        <= e_in;
                        cnt      <= '0;
                        quo      <= '0;
                        state    <= is_special ? SPEC : DIV;
                    end
                end
                DIV: begin
                    rem <= {rem_sub[10:0], 1'b0};
                    quo <= {quo[NQ-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NQ - 1))
                        state <= RND;
                end
                RND: begin
                    q         <= rnd_q;
                    flags     <= rnd_fl;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                SPEC: begin
                    q         <= spec_q;
                    flags     <= spec_fl;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq: hand-computed quotients, flags, latency, backpressure, reset abort.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp16_div_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .roundmode (roundmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one operation; returns once out_valid is seen (n = edges counted from the accept edge).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                         input string tag, output int n);
        @(negedge clk);
        x = a; y = b; roundmode = rm; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                          input logic [15:0] eq, input logic [4:0] ef, input int elat,
                          input string tag);
        int n;
        issue(a, b, rm, tag, n);
        chk({tag, ".lat"}, 32'(n), 32'(elat));
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".flags"}, 32'(flags), 32'(ef));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; roundmode = 2'b01;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.q", 32'(q), 32'h0000);
        chk("rst.flags", 32'(flags), 32'd0);
        reset_n = 1'b1;

        // flags = {NV, DZ, OF, UF, NX}
        run_op(16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'b00000, 15, "two_by_one");
        run_op(16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001, 15, "third_rne");
        run_op(16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'b00001, 15, "third_rz");
        run_op(16'h3C00, 16'h4200, 2'b11, 16'h3556, 5'b00001, 15, "third_rp");
        run_op(16'hBC00, 16'h4200, 2'b10, 16'hB556, 5'b00001, 15, "neg_third_rm");
        run_op(16'h3C00, 16'h0000, 2'b01, 16'h7C00, 5'b01000, 2,  "div_zero");
        run_op(16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'b10000, 2,  "zero_zero");
        run_op(16'h7D00, 16'h3C00, 2'b01, 16'h7E00, 5'b10000, 2,  "snan");
        run_op(16'h7C00, 16'hBC00, 2'b01, 16'hFC00, 5'b00000, 2,  "inf_fin");
        run_op(16'h8000, 16'h3C00, 2'b01, 16'h8000, 5'b00000, 2,  "negzero");
        run_op(16'h7BFF, 16'h1400, 2'b01, 16'h7C00, 5'b00101, 15, "ovf_rne");
        run_op(16'h7BFF, 16'h1400, 2'b00, 16'h7BFF, 5'b00101, 15, "ovf_rz");
        run_op(16'h0400, 16'h7800, 2'b01, 16'h0000, 5'b00011, 15, "unf");

        // Backpressure: result must hold while out_ready stays low.
        issue(16'h4000, 16'h3C00, 2'b01, "bp", n);
        chk("bp.lat", 32'(n), 32'd15);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_q", 32'(q), 32'h4000);
            chk("bp.hold_flags", 32'(flags), 32'd0);
            chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.release_in_ready", 32'(in_ready), 32'd1);
        chk("bp.release_valid", 32'(out_valid), 32'd0);

        // Reset during the 7th DIV cycle abandons the operation.
        @(negedge clk);
        x = 16'h3C00; y = 16'h4200; roundmode = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("abort.no_result", 32'(out_valid), 32'd0);
        run_op(16'hC400, 16'h4000, 2'b01, 16'hC000, 5'b00000, 15, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
